// File: rtl/health_lives_ctrl.sv
// -----------------------------------------------------------------------------
// health_lives_ctrl
//
// Player health controller. Watches the collision hit vector for rising edges.
// A hit in PLAYING is absorbed by an active shield or costs a life; either way
// a timed invulnerability window follows. Losing the last life ends the game
// (OVER) until game_restart.
//
// Optional feature macro: HEALTH_BLINK_EN
//   defined     - donkey_visible blinks with half-period BLINK_CYCLES during
//                 the invulnerability window
//   not defined - no blink counter, donkey_visible is constant 1
//
// Parameters
//   LIVES          lives loaded at reset/restart (1..15)
//   INVULN_CYCLES  invulnerability window length in clk cycles (>= 2)
//   BLINK_CYCLES   blink half-period in clk cycles (>= 1)
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   game_en         gameplay running; low freezes PLAYING/INVULN
//   game_restart    one-cycle pulse: reload lives, back to IDLE
//   hit[9:0]        per-obstacle collision flags
//   is_shielded     shield currently held
//   lives[3:0]      remaining lives
//   game_over       high in OVER
//   invuln          high in INVULN
//   donkey_visible  sprite draw enable
//   damage          one-cycle pulse when a life is lost
//   shield_absorb   one-cycle pulse when the shield absorbs a hit
// -----------------------------------------------------------------------------
module health_lives_ctrl #(
    parameter int LIVES         = 3,
    parameter int INVULN_CYCLES = 65_000_000,
    parameter int BLINK_CYCLES  = 4_062_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic       game_restart,
    input  logic [9:0] hit,
    input  logic       is_shielded,
    output logic [3:0] lives,
    output logic       game_over,
    output logic       invuln,
    output logic       donkey_visible,
    output logic       damage,
    output logic       shield_absorb
);

    localparam int              CW         = $clog2(INVULN_CYCLES);
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(INVULN_CYCLES - 1);
    localparam logic [3:0]      LIVES_INIT = 4'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAYING,
        S_INVULN,
        S_OVER
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_hit_q;
    logic [3:0]    r_lives;
    logic [3:0]    w_lives_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_damage;
    logic          w_damage_next;
    logic          r_absorb;
    logic          w_absorb_next;
    logic          r_game_over;
    logic          r_invuln;
    logic          w_hit_any;
    logic          w_hit_edge;

    assign w_hit_any  = |hit;
    assign w_hit_edge = w_hit_any & ~r_hit_q;

    // Next-state / next-output logic
    always_comb begin
        w_state_next  = r_state;
        w_lives_next  = r_lives;
        w_cnt_next    = r_cnt;
        w_damage_next = 1'b0;
        w_absorb_next = 1'b0;

        if (game_restart) begin
            w_state_next = S_IDLE;
            w_lives_next = LIVES_INIT;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (game_en) begin
                        w_state_next = S_PLAYING;
                    end
                end
                S_PLAYING: begin
                    // A rising edge seen while frozen is dropped, not deferred.
                    if (game_en && w_hit_edge) begin
                        if (is_shielded) begin
                            w_absorb_next = 1'b1;
                            w_state_next  = S_INVULN;
                            w_cnt_next    = CNT_LOAD;
                        end else begin
                            w_damage_next = 1'b1;
                            if (r_lives > 4'd1) begin
                                w_lives_next = r_lives - 4'd1;
                                w_state_next = S_INVULN;
                                w_cnt_next   = CNT_LOAD;
                            end else begin
                                w_lives_next = 4'd0;
                                w_state_next = S_OVER;
                            end
                        end
                    end
                end
                S_INVULN: begin
                    if (game_en) begin
                        if (r_cnt == '0) begin
                            w_state_next = S_PLAYING;
                        end else begin
                            w_cnt_next = r_cnt - 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    w_state_next = S_OVER;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hit_q     <= 1'b0;
            r_lives     <= LIVES_INIT;
            r_cnt       <= '0;
            r_damage    <= 1'b0;
            r_absorb    <= 1'b0;
            r_game_over <= 1'b0;
            r_invuln    <= 1'b0;
        end else begin
            // hit_q tracks the raw hit in every state so a held hit never
            // looks like a fresh edge after a freeze or window exit.
            r_hit_q     <= w_hit_any;
            r_state     <= w_state_next;
            r_lives     <= w_lives_next;
            r_cnt       <= w_cnt_next;
            r_damage    <= w_damage_next;
            r_absorb    <= w_absorb_next;
            r_game_over <= (w_state_next == S_OVER);
            r_invuln    <= (w_state_next == S_INVULN);
        end
    end

`ifdef HEALTH_BLINK_EN
    localparam int            BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_visible;

    always_ff @(posedge clk) begin
        if (rst || game_restart) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if ((r_state != S_INVULN) && (w_state_next == S_INVULN)) begin
            // Window entry: sprite hidden for the first half-period.
            r_blink_cnt <= BLINK_LOAD;
            r_visible   <= 1'b0;
        end else if ((r_state == S_INVULN) && (w_state_next != S_INVULN)) begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
        end else if ((r_state == S_INVULN) && game_en) begin
            if (r_blink_cnt == '0) begin
                r_blink_cnt <= BLINK_LOAD;
                r_visible   <= ~r_visible;
            end else begin
                r_blink_cnt <= r_blink_cnt - 1'b1;
            end
        end
    end

    assign donkey_visible = r_visible;
`else
    // No blink: sprite always drawn; the blink period has no effect here.
    assign donkey_visible = (BLINK_CYCLES >= 1) | 1'b1;
`endif

    assign lives         = r_lives;
    assign game_over     = r_game_over;
    assign invuln        = r_invuln;
    assign damage        = r_damage;
    assign shield_absorb = r_absorb;

endmodule

// File: tb/tb_health_lives_ctrl.sv
// -----------------------------------------------------------------------------
// tb_health_lives_ctrl
//
// Directed stimulus for health_lives_ctrl with LIVES=3, INVULN_CYCLES=8,
// BLINK_CYCLES=2. A behavioural model (lives count, invulnerability age,
// idle/over flags) predicts every output each cycle; directed checks with
// hand-computed values pin the model. Honours HEALTH_BLINK_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_health_lives_ctrl;

    localparam int LIVES  = 3;
    localparam int INV    = 8;
    localparam int BLINK  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_en = 1'b0;
    logic       game_restart = 1'b0;
    logic [9:0] hit = '0;
    logic       is_shielded = 1'b0;
    logic [3:0] lives;
    logic       game_over;
    logic       invuln;
    logic       donkey_visible;
    logic       damage;
    logic       shield_absorb;

    int checks = 0;
    int failures = 0;

    health_lives_ctrl #(
        .LIVES         (LIVES),
        .INVULN_CYCLES (INV),
        .BLINK_CYCLES  (BLINK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .game_en        (game_en),
        .game_restart   (game_restart),
        .hit            (hit),
        .is_shielded    (is_shielded),
        .lives          (lives),
        .game_over      (game_over),
        .invuln         (invuln),
        .donkey_visible (donkey_visible),
        .damage         (damage),
        .shield_absorb  (shield_absorb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit blink_vis(input int age);
`ifdef HEALTH_BLINK_EN
        return ((age / BLINK) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    int m_lives = LIVES;
    bit m_idle = 1, m_over = 0, m_inv = 0;
    int m_age = 0;
    bit m_dmg = 0, m_abs = 0, m_vis = 1, m_hitprev = 0, m_valid = 0;

    always @(posedge clk) begin
        bit h, e;
        h = |hit;
        e = h && !m_hitprev;
        m_hitprev = h;
        m_dmg = 0;
        m_abs = 0;
        m_valid = 1;
        if (rst) begin
            m_lives = LIVES; m_idle = 1; m_over = 0; m_inv = 0;
            m_age = 0; m_vis = 1; m_hitprev = 0;
        end else if (game_restart) begin
            m_lives = LIVES; m_idle = 1; m_over = 0; m_inv = 0;
            m_age = 0; m_vis = 1;
        end else if (m_idle) begin
            if (game_en) m_idle = 0;
        end else if (!m_over && game_en) begin
            if (m_inv) begin
                m_age++;
                if (m_age == INV) begin
                    m_inv = 0;
                    m_vis = 1;
                end else begin
                    m_vis = blink_vis(m_age);
                end
            end else if (e) begin
                if (is_shielded) begin
                    m_abs = 1;
                end else begin
                    m_dmg = 1;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end
                if (m_lives == 0) begin
                    m_over = 1;
                end else begin
                    m_inv = 1;
                    m_age = 0;
                    m_vis = blink_vis(0);
                end
            end
        end
    end

    // ---------------- compare + measurement ----------------
    int inv_cnt = 0, dmg_cnt = 0, abs_cnt = 0;
    bit vis_q[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_lives", int'(lives), m_lives);
            chk("cyc_game_over", int'(game_over), int'(m_over));
            chk("cyc_invuln", int'(invuln), int'(m_inv));
            chk("cyc_visible", int'(donkey_visible), int'(m_vis));
            chk("cyc_damage", int'(damage), int'(m_dmg));
            chk("cyc_absorb", int'(shield_absorb), int'(m_abs));
        end
        if (invuln) begin
            inv_cnt++;
            vis_q.push_back(donkey_visible);
        end
        if (damage) dmg_cnt++;
        if (shield_absorb) abs_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_meas();
        inv_cnt = 0; dmg_cnt = 0; abs_cnt = 0;
        vis_q.delete();
    endtask

    task automatic pulse_hit(input logic [9:0] v);
        hit = v; tick(1); hit = '0;
    endtask

    task automatic restart();
        game_restart = 1'b1; tick(1); game_restart = 1'b0;
        tick(2);
        clear_meas();
    endtask

    initial begin
        bit exp_blink[8];
        exp_blink = '{0, 0, 1, 1, 0, 0, 1, 1};

        tick(3);
        chk("reset_lives", int'(lives), 3);
        chk("reset_game_over", int'(game_over), 0);
        chk("reset_invuln", int'(invuln), 0);
        chk("reset_visible", int'(donkey_visible), 1);
        chk("reset_damage", int'(damage), 0);
        rst = 1'b0; game_en = 1'b1;
        tick(2);
        clear_meas();

        // 1: single unshielded hit
        pulse_hit(10'h001);
        tick(12);
        chk("hit1_lives", int'(lives), 2);
        chk("hit1_inv_cycles", inv_cnt, 8);
        chk("hit1_damage_pulses", dmg_cnt, 1);
        chk("hit1_absorb_pulses", abs_cnt, 0);
        chk("hit1_blink_len", vis_q.size(), 8);
        for (int i = 0; i < 8 && i < vis_q.size(); i++) begin
`ifdef HEALTH_BLINK_EN
            chk($sformatf("blink_%0d", i), int'(vis_q[i]), int'(exp_blink[i]));
`else
            chk($sformatf("blink_%0d", i), int'(vis_q[i]), 1);
`endif
        end
        chk("hit1_visible_after", int'(donkey_visible), 1);

        // 2: shielded hit
        restart();
        is_shielded = 1'b1;
        pulse_hit(10'h200);
        is_shielded = 1'b0;
        tick(12);
        chk("shield_lives", int'(lives), 3);
        chk("shield_absorb_pulses", abs_cnt, 1);
        chk("shield_damage_pulses", dmg_cnt, 0);
        chk("shield_inv_cycles", inv_cnt, 8);

        // 3: hit held for 20 cycles, then a fresh edge
        restart();
        hit = 10'h004; tick(20); hit = '0; tick(2);
        chk("held_lives", int'(lives), 2);
        chk("held_damage_pulses", dmg_cnt, 1);
        pulse_hit(10'h004);
        tick(12);
        chk("held_refresh_lives", int'(lives), 1);

        // 4: three hits to game over, then more hits, then restart
        restart();
        pulse_hit(10'h010); tick(12);
        chk("seq_lives_a", int'(lives), 2);
        pulse_hit(10'h020); tick(12);
        chk("seq_lives_b", int'(lives), 1);
        clear_meas();
        pulse_hit(10'h040); tick(3);
        chk("seq_lives_c", int'(lives), 0);
        chk("seq_game_over", int'(game_over), 1);
        chk("seq_no_invuln", inv_cnt, 0);
        pulse_hit(10'h080); tick(2);
        pulse_hit(10'h080); tick(2);
        chk("over_lives_hold", int'(lives), 0);
        chk("over_damage_pulses", dmg_cnt, 1);
        game_restart = 1'b1; tick(1); game_restart = 1'b0;
        chk("restart_lives", int'(lives), 3);
        chk("restart_game_over", int'(game_over), 0);
        tick(2);

        // 5: freeze mid-window with a hit during the freeze
        clear_meas();
        pulse_hit(10'h001);
        tick(2);
        game_en = 1'b0;
        tick(1);
        hit = 10'h002; tick(1); hit = '0;
        tick(3);
        game_en = 1'b1;
        tick(15);
        chk("freeze_inv_cycles", inv_cnt, 13);
        chk("freeze_lives", int'(lives), 2);
        chk("freeze_damage_pulses", dmg_cnt, 1);

        // 6: reset in the middle of the window
        pulse_hit(10'h001);
        tick(3);
        chk("pre_rst_invuln", int'(invuln), 1);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("rst_mid_invuln", int'(invuln), 0);
        chk("rst_mid_lives", int'(lives), 3);
        chk("rst_mid_visible", int'(donkey_visible), 1);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
